// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS front end: data widths, major opcodes and
// the fetch state encoding.
package mips_pkg;

    localparam int ADDR_W  = 32;
    localparam int INSTR_W = 32;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } fetch_state_e;

    // Instruction fetches are always word aligned; the low address bits are dropped.
    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
        return addr & ~ADDR_W'(3);
    endfunction

endpackage

// File: rtl/mips_fetch_unit_queue.sv
// Small synchronous FIFO holding {instruction, pc} pairs between fetch and decode.
// Flush has priority over push and pop in the same cycle.
module fetch_queue #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    input  logic                   flush,
    output logic [$clog2(DEPTH):0] count,
    output logic                   head_valid,
    output logic [WIDTH-1:0]       head_data
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !flush && (count_q < CW'(DEPTH));
    assign do_pop  = pop && !flush && (count_q != '0);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Head reads as zero when empty so decode never sees stale words.
    assign count      = count_q;
    assign head_valid = (count_q != '0);
    assign head_data  = head_valid ? mem_q[rd_ptr_q] : '0;

endmodule

// File: rtl/mips_fetch_unit.sv
// Instruction fetch front end: PC, single-outstanding memory requests,
// redirect handling and a short queue feeding the decoder.
module mips_fetch_unit
    import mips_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000,
    parameter int                QDEPTH   = 2
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req_valid,
    output logic [ADDR_W-1:0]  imem_req_addr,
    input  logic               imem_req_ready,
    input  logic               imem_rsp_valid,
    input  logic [INSTR_W-1:0] imem_rsp_data,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               dec_valid,
    input  logic               dec_ready,
    output logic [INSTR_W-1:0] dec_instr,
    output logic [ADDR_W-1:0]  dec_pc,
    output logic [5:0]         opCode,
    output logic [5:0]         funct
);

    localparam int CW = $clog2(QDEPTH) + 1;
    localparam int QW = INSTR_W + ADDR_W;

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] req_pc_q, req_pc_d;
    logic              outstanding_q, outstanding_d;
    logic              drop_q, drop_d;

    logic [CW-1:0]     q_count;
    logic              q_head_valid;
    logic [QW-1:0]     q_head_data;
    logic              req_fire;
    logic              rsp_fire;
    logic              q_push;
    logic              q_pop;

    // The outstanding request already owns a queue slot, so a push can never overflow.
    assign imem_req_valid = (state_q == REQ) &&
                            ((32'(q_count) + 32'(outstanding_q)) < 32'(QDEPTH));
    assign imem_req_addr  = pc_q;

    assign req_fire = imem_req_valid && imem_req_ready;
    assign rsp_fire = (state_q == WAIT) && imem_rsp_valid;
    assign q_push   = rsp_fire && !drop_q && !redirect_valid;
    assign q_pop    = q_head_valid && dec_ready && !redirect_valid;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        req_pc_d      = req_pc_q;
        outstanding_d = outstanding_q;
        drop_d        = drop_q;
        case (state_q)
            IDLE: begin
                state_d = REQ;
            end
            REQ: begin
                if (req_fire) begin
                    req_pc_d      = pc_q;
                    pc_d          = pc_q + ADDR_W'(4);
                    outstanding_d = 1'b1;
                    drop_d        = redirect_valid;
                    state_d       = WAIT;
                end
            end
            WAIT: begin
                // A response coinciding with a redirect is discarded and clears drop.
                if (rsp_fire) begin
                    outstanding_d = 1'b0;
                    drop_d        = 1'b0;
                    state_d       = REQ;
                end else if (redirect_valid) begin
                    drop_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (redirect_valid) begin
            pc_d = word_align(redirect_pc);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            pc_q          <= word_align(RESET_PC);
            req_pc_q      <= '0;
            outstanding_q <= 1'b0;
            drop_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            req_pc_q      <= req_pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
        end
    end

    fetch_queue #(
        .WIDTH (QW),
        .DEPTH (QDEPTH)
    ) u_queue (
        .clk        (clk),
        .reset      (reset),
        .push       (q_push),
        .push_data  ({imem_rsp_data, req_pc_q}),
        .pop        (q_pop),
        .flush      (redirect_valid),
        .count      (q_count),
        .head_valid (q_head_valid),
        .head_data  (q_head_data)
    );

    assign dec_valid = q_head_valid;
    assign dec_instr = q_head_data[QW-1:ADDR_W];
    assign dec_pc    = q_head_data[ADDR_W-1:0];
    assign opCode    = dec_instr[31:26];
    assign funct     = dec_instr[5:0];

endmodule
